// File: rtl/div_unit_pkg.sv
// div_unit_pkg
// Shared definitions for the multi-cycle divider: FSM state codes,
// ready/start literals, the 64-bit HI/LO result bus type and a helper
// that forms the operand magnitude for signed or unsigned division.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // {remainder, quotient}, written to HI/LO by the execute stage
  typedef logic [63:0] double_reg_bus_t;

  // Two's-complement magnitude when the operation is signed, raw value
  // otherwise. 0x80000000 maps onto itself, which is still the correct
  // unsigned magnitude.
  function automatic logic [31:0] op_magnitude(input logic [31:0] value,
                                               input logic        is_signed);
    return (is_signed && value[31]) ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step
// One radix-2 restoring division step (purely combinational).
// Ports:
//   rem_i     - shifted partial remainder {rem, next dividend bit}, 33 bits
//   divisor_i - divisor magnitude
//   rem_o     - partial remainder after the trial subtraction/restore
//   quo_bit_o - quotient bit produced by this step
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         quo_bit_o
);

  logic [W:0] diff;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rem_o     = rem_i[W-1:0];
    quo_bit_o = 1'b0;
    diff      = rem_i - {1'b0, divisor_i};
    // A clear borrow bit means the divisor fit: keep the difference.
    // The partial remainder is always below the divisor afterwards, so
    // the low W bits hold it exactly in both branches.
    if (!diff[W]) begin
      rem_o     = diff[W-1:0];
      quo_bit_o = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit
// Multi-cycle 32-bit divider for DIV/DIVU beside the execute stage.
// Radix-2 restoring, one quotient bit per cycle; the execute stage holds
// start_i until ready_o and then writes result_o to HI (remainder) and
// LO (quotient).
// Ports:
//   clk          - system clock
//   rst          - asynchronous active-low reset
//   signed_div_i - 1 = DIV (signed), 0 = DIVU
//   opdata1_i    - dividend
//   opdata2_i    - divisor
//   start_i      - request, held until ready_o
//   annul_i      - cancel the operation in flight
//   result_o     - {remainder, quotient}
//   ready_o      - result valid
// Configuration:
//   DIV_EARLY_OUT_EN - when defined, a dividend magnitude strictly below
//   the divisor magnitude finishes straight away (quo=0, rem=dividend).
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32  // only 32 is supported
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  div_state_e  state_q;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q;     // partial remainder
  logic [31:0] dvd_q;     // dividend bits shift out, quotient bits shift in
  logic [31:0] dsr_q;     // divisor magnitude
  logic        signed_q;
  logic        neg1_q;    // dividend was negative (signed only)
  logic        neg2_q;    // divisor was negative (signed only)

  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [31:0] step_rem;
  logic        step_quo;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign mag1 = op_magnitude(opdata1_i, signed_div_i);
  assign mag2 = op_magnitude(opdata2_i, signed_div_i);

  div_step #(.W(32)) u_step (
    .rem_i     ({rem_q, dvd_q[31]}),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .quo_bit_o (step_quo)
  );

  // Sign correction: quotient negative when the signs differ, remainder
  // follows the dividend. 0x80000000 / -1 wraps to 0x80000000.
  assign quo_fix = (signed_q && (neg1_q ^ neg2_q)) ? (~dvd_q + 32'd1) : dvd_q;
  assign rem_fix = (signed_q && neg1_q) ? (~rem_q + 32'd1) : rem_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      rem_q    <= ZERO_WORD;
      dvd_q    <= ZERO_WORD;
      dsr_q    <= ZERO_WORD;
      signed_q <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state_q)
        DIV_FREE: begin
          ready_o  <= DIV_RESULT_NOT_READY;
          result_o <= '0;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == ZERO_WORD) begin
              // Zero operands make the END sign fix-up produce zero.
              rem_q    <= ZERO_WORD;
              dvd_q    <= ZERO_WORD;
              signed_q <= 1'b0;
              neg1_q   <= 1'b0;
              neg2_q   <= 1'b0;
              state_q  <= DIV_BY_ZERO;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (mag1 < mag2) begin
              // rem = |dividend| re-signed by END equals opdata1_i itself.
              rem_q    <= mag1;
              dvd_q    <= ZERO_WORD;
              signed_q <= signed_div_i;
              neg1_q   <= signed_div_i & opdata1_i[31];
              neg2_q   <= signed_div_i & opdata2_i[31];
              state_q  <= DIV_END;
            end
`endif
            else begin
              rem_q    <= ZERO_WORD;
              dvd_q    <= mag1;
              dsr_q    <= mag2;
              signed_q <= signed_div_i;
              neg1_q   <= signed_div_i & opdata1_i[31];
              neg2_q   <= signed_div_i & opdata2_i[31];
              cnt_q    <= '0;
              state_q  <= DIV_ON;
            end
          end
        end

        DIV_BY_ZERO: begin
          state_q <= annul_i ? DIV_FREE : DIV_END;
        end

        DIV_ON: begin
          if (annul_i) begin
            state_q <= DIV_FREE;
          end else begin
            rem_q <= step_rem;
            dvd_q <= {dvd_q[30:0], step_quo};
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_q <= DIV_END;
            end
          end
        end

        DIV_END: begin
          // annul_i is deliberately not looked at here.
          if (start_i == DIV_START) begin
            ready_o  <= DIV_RESULT_READY;
            result_o <= {rem_fix, quo_fix};
          end else begin
            ready_o  <= DIV_RESULT_NOT_READY;
            result_o <= '0;
            state_q  <= DIV_FREE;
          end
        end

        default: state_q <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit
// Directed-vector bench for div_unit with hand-computed results.
`timescale 1ns/1ps
module tb_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif
  localparam int BUDGET = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_vec  = 0;
  int n_miss = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Raise start with the operands, scramble the operands after they are
  // sampled, and count edges after edge 0 until ready_o (start stays high).
  task automatic start_and_wait(input logic sgn, input logic [31:0] a,
                                input logic [31:0] b, output int lat);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);  // edge 0
    #1;
    opdata1_i = ~a;
    opdata2_i = ~b ^ 32'h5;
    lat = 999;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_div(input string tag, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_res, input int exp_lat);
    int lat;
    start_and_wait(sgn, a, b, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, result_o, exp_res);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_drop_rdy"}, {63'd0, ready_o}, 64'd0);
    check({tag, "_drop_res"}, result_o, 64'd0);
  endtask

  initial begin
    int   lat;
    logic seen;
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #12;
    check("reset_rdy", {63'd0, ready_o}, 64'd0);
    check("reset_res", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div("u100_7",    1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33);
    run_div("s_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33);
    run_div("s7_m2",     1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33);
    run_div("divzero",   1'b0, 32'h1234,       32'd0,          64'h0,                 2);
    run_div("s_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33);
    run_div("u_ovf",     1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, EO_LAT);
    run_div("u3_10",     1'b0, 32'd3,          32'd10,         64'h00000003_00000000, EO_LAT);

    // Annul at ON cycle 10, then an immediate fresh start.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(posedge clk);  // edge 0, now in ON
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_rdy", {63'd0, ready_o}, 64'd0);
    annul_i = 1'b0;
    run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // start and annul together in FREE must not start anything.
    @(negedge clk);
    opdata1_i = 32'h1234;
    opdata2_i = 32'd0;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    seen      = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1'b1;
    end
    check("start_annul_idle", {63'd0, seen}, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;

    // Asynchronous reset at ON cycle 20.
    @(negedge clk);
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_on_rdy", {63'd0, ready_o}, 64'd0);
    check("rst_on_res", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset while a result is being presented.
    start_and_wait(1'b0, 32'd100, 32'd7, lat);
    check("pre_rst_res", result_o, 64'h00000002_0000000E);
    #2;
    rst = 1'b0;
    #1;
    check("rst_end_rdy", {63'd0, ready_o}, 64'd0);
    check("rst_end_res", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    run_div("after_rst_1000_3", 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
